// File: rtl/seq_shift_add_multiplier.sv
// ============================================================================
// Module   : seq_shift_add_multiplier
// Purpose  : Sequential shift-add multiplier, one partial product per clock,
//            start/busy/done handshake, registered 2*WIDTH-bit product.
//            Optional macro SIGNED_MULT_EN: two's complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [2*WIDTH-1:0]   r_mcand,   w_mcand_nxt;
    logic [WIDTH-1:0]     r_mplr,    w_mplr_nxt;
    logic [2*WIDTH-1:0]   r_acc,     w_acc_nxt;
    logic [CNT_W-1:0]     r_count,   w_count_nxt;
    logic                 r_done,    w_done_nxt;
    logic [2*WIDTH-1:0]   r_product, w_product_nxt;

    logic [2*WIDTH-1:0]   w_acc_sum;
    logic [2*WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]     w_load_a;
    logic [WIDTH-1:0]     w_load_b;
    logic                 w_last;

    assign w_acc_sum = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));

`ifdef SIGNED_MULT_EN
    logic r_sign, w_sign_nxt;

    // Magnitudes as unsigned WIDTH bits: the most-negative value maps to 2^(WIDTH-1)
    assign w_load_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_load_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign w_result = r_sign ? (~w_acc_sum + (2*WIDTH)'(1)) : w_acc_sum;
`else
    assign w_load_a = a;
    assign w_load_b = b;
    assign w_result = w_acc_sum;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplr_nxt    = r_mplr;
        w_acc_nxt     = r_acc;
        w_count_nxt   = r_count;
        w_done_nxt    = 1'b0;
        w_product_nxt = r_product;
`ifdef SIGNED_MULT_EN
        w_sign_nxt    = r_sign;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mcand_nxt = {{WIDTH{1'b0}}, w_load_a};
                    w_mplr_nxt  = w_load_b;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_RUN;
`ifdef SIGNED_MULT_EN
                    w_sign_nxt  = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                w_acc_nxt   = w_acc_sum;
                w_mcand_nxt = r_mcand << 1;
                w_mplr_nxt  = r_mplr >> 1;
                w_count_nxt = r_count + CNT_W'(1);
                if (w_last) begin
                    w_product_nxt = w_result;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
`ifdef SIGNED_MULT_EN
            r_sign    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplr    <= w_mplr_nxt;
            r_acc     <= w_acc_nxt;
            r_count   <= w_count_nxt;
            r_done    <= w_done_nxt;
            r_product <= w_product_nxt;
`ifdef SIGNED_MULT_EN
            r_sign    <= w_sign_nxt;
`endif
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire
